avmm_slave_router: RTL and testbench

- Avalon-MM slave-side router directly downstream of the EMIF16-to-Avalon-MM bridge.
- Takes the bridge's single-command master interface and decodes one address bit to forward each command to one of two Avalon-MM slave windows.
- Registers every forwarded command.
- Enforces a per-transaction timeout: a stalled slave cannot hang the EMIF16 bus. On timeout, the router returns an error pattern and sets a sticky status flag.

---
 rtl/avmm_pkg.sv | 24 ++
 rtl/avmm_slave_router.sv | 213 +++++++++++++++++++++
 tb/tb_avmm_slave_router.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/avmm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : avmm_pkg
// Description : Shared types and constants for the Avalon-MM slave router:
//               router state encoding, default timeout error pattern and
//               Avalon width defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package avmm_pkg;

  // Router states: accept a command, hold it on the slave, return it upstream
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } router_state_t;

  localparam int          c_addr_w   = 24;
  localparam int          c_data_w   = 16;
  localparam int          c_be_w     = c_data_w / 8;
  localparam logic [15:0] c_err_data = 16'hDEAD;

endpackage : avmm_pkg
`default_nettype wire

// File: rtl/avmm_slave_router.sv
`default_nettype none
// ============================================================================
// Module      : avmm_slave_router
// Description : Routes single Avalon-MM commands from the EMIF16 bridge to one
//               of two slave windows selected by one address bit. Commands are
//               registered, held until the slave accepts, and aborted with an
//               error read pattern if the slave stalls too long.
// Revision    : 1.0 - initial release
// ============================================================================
module avmm_slave_router
  import avmm_pkg::*;
#(
  parameter int                 ADDR_W         = c_addr_w,
  parameter int                 DATA_W         = c_data_w,
  parameter int                 SEL_BIT        = 23,
  parameter int                 TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0]  ERR_DATA       = DATA_W'(c_err_data)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // upstream (bridge) side
  input  logic [ADDR_W-1:0]     s_address_i,
  input  logic [DATA_W-1:0]     s_writedata_i,
  input  logic [DATA_W/8-1:0]   s_byteenable_i,
  input  logic                  s_write_i,
  input  logic                  s_read_i,
  output logic [DATA_W-1:0]     s_readdata_o,
  output logic                  s_waitrequest_o,
  // slave window 0
  output logic [ADDR_W-2:0]     m0_address_o,
  output logic [DATA_W-1:0]     m0_writedata_o,
  output logic [DATA_W/8-1:0]   m0_byteenable_o,
  output logic                  m0_write_o,
  output logic                  m0_read_o,
  input  logic [DATA_W-1:0]     m0_readdata_i,
  input  logic                  m0_waitrequest_i,
  // slave window 1
  output logic [ADDR_W-2:0]     m1_address_o,
  output logic [DATA_W-1:0]     m1_writedata_o,
  output logic [DATA_W/8-1:0]   m1_byteenable_o,
  output logic                  m1_write_o,
  output logic                  m1_read_o,
  input  logic [DATA_W-1:0]     m1_readdata_i,
  input  logic                  m1_waitrequest_i,
  // timeout status
  input  logic                  clr_timeout_i,
  output logic                  timeout_o,
  output logic [7:0]            timeout_cnt_o
);

  localparam int c_be_w_l = DATA_W / 8;
  localparam int c_cnt_w  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  router_state_t          r_state;
  router_state_t          w_state_next;

  logic [ADDR_W-2:0]      w_addr_strip;
  logic [ADDR_W-2:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic [c_be_w_l-1:0]    r_be;
  logic                   r_sel;
  logic                   r_is_write;
  logic [DATA_W-1:0]      r_rdata;

  logic                   r_m0_read;
  logic                   r_m0_write;
  logic                   r_m1_read;
  logic                   r_m1_write;

  logic [c_cnt_w-1:0]     r_cnt;
  logic                   r_timeout;
  logic [7:0]             r_timeout_cnt;

  logic                   w_req;
  logic                   w_start;
  logic                   w_slave_wait;
  logic [DATA_W-1:0]      w_slave_rdata;
  logic                   w_ack;
  logic                   w_expire;

  assign w_req         = s_read_i | s_write_i;
  assign w_start       = (r_state == IDLE) && w_req;
  assign w_slave_wait  = r_sel ? m1_waitrequest_i : m0_waitrequest_i;
  assign w_slave_rdata = r_sel ? m1_readdata_i    : m0_readdata_i;

  // Drop the window-select bit from the upstream address, closing the gap
  always_comb begin
    w_addr_strip = '0;
    for (int i = 0; i < ADDR_W - 1; i++) begin
      w_addr_strip[i] = (i < SEL_BIT) ? s_address_i[i] : s_address_i[i+1];
    end
  end

  // Next-state decode; acceptance by the slave takes priority over expiry
  always_comb begin
    w_state_next = r_state;
    w_ack        = 1'b0;
    w_expire     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) w_state_next = ISSUE;
      end
      ISSUE: begin
        if (!w_slave_wait) begin
          w_ack        = 1'b1;
          w_state_next = DONE;
        end else if (r_cnt == c_cnt_last) begin
          w_expire     = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // Latch the upstream command when it is first seen in IDLE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_sel      <= 1'b0;
      r_is_write <= 1'b0;
    end else if (w_start) begin
      r_addr     <= w_addr_strip;
      r_wdata    <= s_writedata_i;
      r_be       <= s_byteenable_i;
      r_sel      <= s_address_i[SEL_BIT];
      r_is_write <= s_write_i;
    end
  end

  // Strobe only the selected window; a simultaneous read+write becomes a write
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_m0_read  <= 1'b0;
      r_m0_write <= 1'b0;
      r_m1_read  <= 1'b0;
      r_m1_write <= 1'b0;
    end else if (w_start) begin
      r_m0_read  <= !s_address_i[SEL_BIT] && !s_write_i;
      r_m0_write <= !s_address_i[SEL_BIT] &&  s_write_i;
      r_m1_read  <=  s_address_i[SEL_BIT] && !s_write_i;
      r_m1_write <=  s_address_i[SEL_BIT] &&  s_write_i;
    end else if (w_ack || w_expire) begin
      r_m0_read  <= 1'b0;
      r_m0_write <= 1'b0;
      r_m1_read  <= 1'b0;
      r_m1_write <= 1'b0;
    end
  end

  // Cycles spent in ISSUE; zero whenever the router is elsewhere
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                r_cnt <= '0;
    else if (r_state != ISSUE)  r_cnt <= '0;
    else                        r_cnt <= r_cnt + 1'b1;
  end

  // Read data returned upstream; writes leave the last read value in place
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                       r_rdata <= '0;
    else if (w_ack && !r_is_write)     r_rdata <= w_slave_rdata;
    else if (w_expire && !r_is_write)  r_rdata <= ERR_DATA;
  end

  // Sticky timeout flag and saturating count; a new event beats a clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_timeout     <= 1'b0;
      r_timeout_cnt <= '0;
    end else if (w_expire) begin
      r_timeout     <= 1'b1;
      if (clr_timeout_i)              r_timeout_cnt <= 8'd1;
      else if (r_timeout_cnt != 8'hFF) r_timeout_cnt <= r_timeout_cnt + 8'd1;
    end else if (clr_timeout_i) begin
      r_timeout     <= 1'b0;
      r_timeout_cnt <= '0;
    end
  end

  assign s_waitrequest_o = (r_state != DONE);
  assign s_readdata_o    = r_rdata;

  assign m0_address_o    = r_addr;
  assign m0_writedata_o  = r_wdata;
  assign m0_byteenable_o = r_be;
  assign m0_read_o       = r_m0_read;
  assign m0_write_o      = r_m0_write;

  assign m1_address_o    = r_addr;
  assign m1_writedata_o  = r_wdata;
  assign m1_byteenable_o = r_be;
  assign m1_read_o       = r_m1_read;
  assign m1_write_o      = r_m1_write;

  assign timeout_o       = r_timeout;
  assign timeout_cnt_o   = r_timeout_cnt;

endmodule : avmm_slave_router
`default_nettype wire

// File: tb/tb_avmm_slave_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_avmm_slave_router
// Description : Directed bench for avmm_slave_router. The driver pushes the
//               expected response of each command into a queue; a monitor pops
//               and compares whenever the router releases s_waitrequest_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avmm_slave_router;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] s_address = '0;
  logic [15:0] s_writedata = '0;
  logic [1:0]  s_byteenable = '0;
  logic        s_write = 1'b0;
  logic        s_read = 1'b0;
  logic [15:0] s_readdata;
  logic        s_waitrequest;
  logic [22:0] m0_address, m1_address;
  logic [15:0] m0_writedata, m1_writedata;
  logic [1:0]  m0_byteenable, m1_byteenable;
  logic        m0_write, m0_read, m1_write, m1_read;
  logic [15:0] m0_readdata = '0, m1_readdata = '0;
  logic        m0_waitrequest, m1_waitrequest;
  logic        clr_timeout = 1'b0;
  logic        timeout;
  logic [7:0]  timeout_cnt;

  int checks = 0;
  int errors = 0;

  // slave models: hold waitrequest for wN cycles of strobe, then accept
  int w0 = 0, w1 = 0;
  int c0 = 0, c1 = 0;

  always @(posedge clk) begin
    c0 <= (m0_read || m0_write) ? c0 + 1 : 0;
    c1 <= (m1_read || m1_write) ? c1 + 1 : 0;
  end
  assign m0_waitrequest = !((m0_read || m0_write) && c0 >= w0);
  assign m1_waitrequest = !((m1_read || m1_write) && c1 >= w1);

  avmm_slave_router #(
    .ADDR_W(24), .DATA_W(16), .SEL_BIT(23), .TIMEOUT_CYCLES(8), .ERR_DATA(16'hDEAD)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_address_i(s_address), .s_writedata_i(s_writedata), .s_byteenable_i(s_byteenable),
    .s_write_i(s_write), .s_read_i(s_read),
    .s_readdata_o(s_readdata), .s_waitrequest_o(s_waitrequest),
    .m0_address_o(m0_address), .m0_writedata_o(m0_writedata), .m0_byteenable_o(m0_byteenable),
    .m0_write_o(m0_write), .m0_read_o(m0_read),
    .m0_readdata_i(m0_readdata), .m0_waitrequest_i(m0_waitrequest),
    .m1_address_o(m1_address), .m1_writedata_o(m1_writedata), .m1_byteenable_o(m1_byteenable),
    .m1_write_o(m1_write), .m1_read_o(m1_read),
    .m1_readdata_i(m1_readdata), .m1_waitrequest_i(m1_waitrequest),
    .clr_timeout_i(clr_timeout), .timeout_o(timeout), .timeout_cnt_o(timeout_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic        wr;
    logic [22:0] maddr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] rdata;
    int          strobes;
    logic        to;
    logic [7:0]  tocnt;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // monitor: per-cycle strobe accounting, per-completion response check
  int good = 0, bad = 0, lat = 0;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good = 0; bad = 0; lat = 0;
    end else begin
      if (s_read || s_write) lat++;
      if (q.size() > 0) begin
        exp_t e;
        int   hit, total;
        e     = q[0];
        total = int'(m0_read) + int'(m0_write) + int'(m1_read) + int'(m1_write);
        hit   = e.sel ? int'(e.wr ? m1_write : m1_read) : int'(e.wr ? m0_write : m0_read);
        good += hit;
        bad  += total - hit;
        if (hit == 1) begin
          chk("m_address", e.sel ? m1_address : m0_address, e.maddr);
          chk("m_byteenable", e.sel ? m1_byteenable : m0_byteenable, e.be);
          if (e.wr) chk("m_writedata", e.sel ? m1_writedata : m0_writedata, e.wdata);
        end
      end
      if (!s_waitrequest) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("s_readdata", s_readdata, e.rdata);
          chk("strobe_cycles", good, e.strobes);
          chk("stray_strobes", bad, 0);
          chk("latency", lat, e.strobes + 2);
          chk("timeout_o", timeout, e.to);
          chk("timeout_cnt_o", timeout_cnt, e.tocnt);
        end
        good = 0; bad = 0; lat = 0;
      end
    end
  end

  task automatic cmd(input logic [23:0] a, input logic r, input logic w,
                     input logic [15:0] wd, input logic [1:0] be, input int wait_n,
                     input logic [15:0] sd, input logic [15:0] exp_rd,
                     input int exp_strb, input logic exp_to, input logic [7:0] exp_cnt);
    exp_t e;
    int   n;
    e.sel = a[23]; e.wr = w; e.maddr = a[22:0]; e.wdata = wd; e.be = be;
    e.rdata = exp_rd; e.strobes = exp_strb; e.to = exp_to; e.tocnt = exp_cnt;
    q.push_back(e);
    if (a[23]) begin w1 = wait_n; m1_readdata = sd; end
    else       begin w0 = wait_n; m0_readdata = sd; end
    @(posedge clk); #1;
    s_address = a; s_read = r; s_write = w; s_writedata = wd; s_byteenable = be;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (s_waitrequest && n < 200);
    if (s_waitrequest) chk("completion_bound", 0, 1);
    @(posedge clk); #1;
    s_read = 1'b0; s_write = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_waitrequest", s_waitrequest, 1);
    chk("rst_strobes", {m0_read, m0_write, m1_read, m1_write}, 4'b0000);
    chk("rst_readdata", s_readdata, 16'h0000);
    chk("rst_timeout", {timeout, timeout_cnt}, 9'h000);
    #1 rst_n = 1'b1;

    // zero-wait read from slave 0
    cmd(24'h000010, 1, 0, 16'h0000, 2'b11, 0, 16'h1234, 16'h1234, 1, 0, 8'd0);
    // write to slave 1 after 4 wait cycles; read data unchanged
    cmd(24'h800020, 0, 1, 16'hA5A5, 2'b01, 4, 16'h0000, 16'h1234, 5, 0, 8'd0);
    // stalled slave 0 read times out after 8 strobe cycles
    cmd(24'h000030, 1, 0, 16'h0000, 2'b11, 1000, 16'h1111, 16'hDEAD, 8, 1, 8'd1);

    // standalone clear
    @(posedge clk); #1 clr_timeout = 1'b1;
    @(posedge clk); #1 clr_timeout = 1'b0;
    @(negedge clk);
    chk("clr_flags", {timeout, timeout_cnt}, 9'h000);

    // acceptance on the final allowed cycle beats the timeout
    cmd(24'h000040, 1, 0, 16'h0000, 2'b11, 7, 16'h4321, 16'h4321, 8, 0, 8'd0);
    // read and write together: write wins, read data untouched
    cmd(24'h000044, 1, 1, 16'h0F0F, 2'b10, 1, 16'h9999, 16'h4321, 2, 0, 8'd0);
    // zero-wait read from slave 1
    cmd(24'h800004, 1, 0, 16'h0000, 2'b11, 0, 16'hBEEF, 16'hBEEF, 1, 0, 8'd0);
    // first timeout on slave 1
    cmd(24'h800008, 1, 0, 16'h0000, 2'b11, 1000, 16'h2222, 16'hDEAD, 8, 1, 8'd1);
    // second timeout (a write) coinciding with a clear: event wins, count=1
    fork
      cmd(24'h000050, 0, 1, 16'h1357, 2'b11, 1000, 16'h0000, 16'hDEAD, 8, 1, 8'd1);
      begin
        @(posedge clk);
        repeat (8) @(posedge clk);
        #1 clr_timeout = 1'b1;
        @(posedge clk); #1 clr_timeout = 1'b0;
      end
    join
    // 256 further timeouts: count saturates at 255
    for (int i = 0; i < 256; i++) begin
      cmd(24'h000060, 1, 0, 16'h0000, 2'b11, 1000, 16'h0000, 16'hDEAD, 8, 1,
          (i + 2 > 255) ? 8'd255 : 8'(i + 2));
    end
    @(negedge clk);
    chk("saturated_cnt", timeout_cnt, 8'd255);

    // reset in the middle of an issued read to slave 1
    w1 = 1000;
    @(posedge clk); #1 s_address = 24'h800000; s_read = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_issue_strobe", m1_read, 1);
    rst_n = 1'b0;
    #1;
    chk("async_strobes", {m0_read, m0_write, m1_read, m1_write}, 4'b0000);
    chk("async_waitrequest", s_waitrequest, 1);
    s_read = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_waitrequest", s_waitrequest, 1);
    chk("post_rst_flags", {timeout, timeout_cnt}, 9'h000);
    chk("post_rst_readdata", s_readdata, 16'h0000);
    // new read completes normally after reset
    cmd(24'h000042, 1, 0, 16'h0000, 2'b01, 2, 16'h5A5A, 16'h5A5A, 3, 0, 8'd0);

    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // absolute bound so the run always terminates
  initial begin
    #2000000;
    $display("FAIL global_time_bound actual=expired required=finished");
    $fatal(1, "time bound");
  end

endmodule : tb_avmm_slave_router
`default_nettype wire
